fdiv_iter: RTL and testbench
============================

Name: fdiv_iter

Overview:
- Iterative single-precision floating-point divider: y = x1 / x2.
- Sits in the FPU next to fmul and shares its operand/result conventions (x1, x2, y, ovf).
- Computes one quotient bit per cycle with a radix-2 restoring mantissa divider.
- Uses a valid/ready handshake and a fixed latency, so the bench can check it against shortreal division the same way fmul is checked.

Parameters:
- QBITS, 26: number of quotient bits generated (1 integer + 23 fraction + guard + round). Must be ≥26. Latency depends on it.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- x1  input  32  dividend, IEEE-754 single.
- x2  input  32  divisor, IEEE-754 single.
- valid_in  input  1  operand valid.
- ready  output  1  high when idle and able to accept.
- y  output  32  quotient, IEEE-754 single.
- ovf  output  1  overflow flag; finite inputs gave a result with exponent ≥255.
- valid_out  output  1  one-cycle pulse marking y/ovf valid.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, y=0, ovf=0, valid_out=0, ready=1. Any in-flight operation is discarded and no valid_out is produced for it.
- Handshake: accept on the rising edge where valid_in && ready; x1/x2 are latched then. valid_in while busy is ignored and does not queue.
- FSM:
  - IDLE: ready=1; on accept go to PREP.
  - PREP (1 cycle): unpack fields, classify the operation, align mantissas.
  - DIV (QBITS cycles): one quotient bit per cycle.
  - ROUND (1 cycle): round, pack, register y/ovf and assert valid_out.
  - Return to IDLE on the next edge.
- Latency: valid_out is high in cycle accept+QBITS+2, i.e. accept+28 by default. Latency is the same for every operand class, including special cases.
- back-to-back: ready returns high in the cycle after valid_out, so the next accept can occur at accept+QBITS+3.
- y/ovf hold their values until the next ROUND; valid_out is high for exactly one cycle.
- Unpack:
  - sign = x1[31]^x2[31].
  - ma = {1,x1[22:0]}, mb = {1,x2[22:0]} (24 bits).
  - Denormal inputs (exp=0) are treated as signed zero.
- Alignment: if ma<mb, shift ma left 1 and set adj=1, otherwise adj=0. This gives a quotient in [1,2).
- Exponent: e = x1[30:23] - x2[30:23] + 127 - adj, computed signed at 10 bits.
- Divider: remainder register width 25 bits. Each cycle: r' = r - mb; if r' ≥0, q bit=1 and r=r'<<1; else q bit=0 and r=r<<1.
- Rounding: sticky = (final r != 0). Round to nearest even on {guard, round, sticky}. A carry out of the mantissa (1.111..+ulp) sets mantissa=0 and e+1.
- Result packing, in priority order:
  1. x1 or x2 has exp=255: y={sign,8'hFF,23'h0}, ovf=0.
  2. x2 zero, x1 nonzero: y={sign,8'hFF,0}, ovf=0.
  3. x1 zero (including 0/0): y={sign,31'h0}, ovf=0.
  4. e ≥255 after rounding: y={sign,8'hFF,0}, ovf=1.
  5. e ≤0: y={sign,31'h0}, ovf=0 (flush to zero, no denormal output).
  6. Otherwise: y={sign,e[7:0],mant[22:0]}.
- Accuracy: for normal inputs with a normal finite result, |y - ref| ≤1 ulp against the shortreal quotient.

Test Plan:
- Simple divide: x1=0x40C00000, x2=0x40000000, valid_in for 1 cycle → y=0x40400000, ovf=0, valid_out exactly at accept+28, ready low from accept+1 to accept+28.
- Rounding (RNE): x1=0x3F800000, x2=0x40400000 → y=0x3EAAAAAB. Also x1=0x3FFFFFFF, x2=0x3F800001 → y=0x3FFFFFFD, checked for 1-ulp tolerance vs shortreal.
- Special classes:
  - 0x7F000000/0x3E800000 → y=0x7F800000, ovf=1.
  - 0xBF800000/0x00000000 → y=0xFF800000, ovf=0.
  - 0x00800000/0x7F000000 → y=0x00000000, ovf=0.
  - 0x80000000/0x40000000 → y=0x80000000.
- Handshake: hold valid_in=1 with changing operands → only the operands present at each ready-high edge are accepted; results arrive 29 cycles apart; no valid_out is dropped or duplicated.
- Reset mid-operation: assert rstn=0 at accept+10 for 1 cycle → y=0, valid_out=0 immediately (asynchronously), ready=1; no valid_out for the aborted op; the next op completes normally.
- Random regression: 10^6 $urandom operand pairs → miss=0 under the fmul bench criteria (diff<2, normal non-inf operands and results).

Source files
------------

// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider, y = x1 / x2.
// Radix-2 restoring mantissa divide, one quotient bit per cycle, with a fixed latency of QBITS+2.
module fdiv_iter #(
   parameter int QBITS = 26
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        valid_in,
   output logic        ready,
   output logic [31:0] y,
   output logic        ovf,
   output logic        valid_out
);

   typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;

   localparam int CW = $clog2(QBITS + 1);
   // quotient bits below the round bit only feed sticky
   localparam logic [QBITS-1:0] LOW_MASK = QBITS'((64'd1 << (QBITS - 26)) - 64'd1);

   state_t             state, state_nx;
   logic [31:0]        a_q, b_q;
   logic               sign_q, special_q, bzero_q, azero_q;
   logic signed [9:0]  e_q;
   logic [23:0]        mb_q;
   logic [24:0]        r_q;
   logic [QBITS-1:0]   q_q;
   logic [CW-1:0]      cnt_q;
   logic [31:0]        y_q;
   logic               ovf_q;

   logic [23:0]        ma, mb;
   logic               adj;
   logic signed [9:0]  e_prep;
   logic [25:0]        diff;
   logic               ge;
   logic [24:0]        r_nx;
   logic               g, rb, sticky, lsb, up;
   logic [24:0]        mant;
   logic signed [9:0]  e_r;
   logic [31:0]        y_rnd;
   logic               ovf_rnd;

   always_comb begin
      ma     = {1'b1, a_q[22:0]};
      mb     = {1'b1, b_q[22:0]};
      adj    = (ma < mb);
      e_prep = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
               + 10'sd127 - $signed({9'd0, adj});
   end

   // remainder stays below 2*mb, so the bit shifted out is always zero
   always_comb begin
      diff = {1'b0, r_q} - {2'b00, mb_q};
      ge   = ~diff[25];
      r_nx = ge ? {diff[23:0], 1'b0} : {r_q[23:0], 1'b0};
   end

   always_comb begin
      g       = q_q[QBITS-25];
      rb      = q_q[QBITS-26];
      lsb     = q_q[QBITS-24];
      sticky  = (|r_q) | (|(q_q & LOW_MASK));
      up      = g & (rb | sticky | lsb);
      mant    = {1'b0, q_q[QBITS-1 -: 24]} + {24'd0, up};
      e_r     = e_q + $signed({9'd0, mant[24]});
      y_rnd   = {sign_q, e_r[7:0], mant[22:0]};
      ovf_rnd = 1'b0;
      if (special_q)
         y_rnd = {sign_q, 8'hFF, 23'h0};
      else if (bzero_q && !azero_q)
         y_rnd = {sign_q, 8'hFF, 23'h0};
      else if (azero_q)
         y_rnd = {sign_q, 31'h0};
      else if (e_r >= 10'sd255) begin
         y_rnd   = {sign_q, 8'hFF, 23'h0};
         ovf_rnd = 1'b1;
      end else if (e_r <= 10'sd0)
         y_rnd = {sign_q, 31'h0};
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (valid_in) state_nx = PREP;
         PREP:    state_nx = DIV;
         DIV:     if (cnt_q == CW'(QBITS - 1)) state_nx = ROUND;
         ROUND:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_q       <= '0;
         b_q       <= '0;
         sign_q    <= 1'b0;
         special_q <= 1'b0;
         bzero_q   <= 1'b0;
         azero_q   <= 1'b0;
         e_q       <= '0;
         mb_q      <= '0;
         r_q       <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_in) begin
               a_q <= x1;
               b_q <= x2;
            end
            PREP: begin
               sign_q    <= a_q[31] ^ b_q[31];
               special_q <= (&a_q[30:23]) | (&b_q[30:23]);
               bzero_q   <= ~(|b_q[30:23]);
               azero_q   <= ~(|a_q[30:23]);
               e_q       <= e_prep;
               mb_q      <= mb;
               r_q       <= adj ? {ma, 1'b0} : {1'b0, ma};
               q_q       <= '0;
               cnt_q     <= '0;
            end
            DIV: begin
               r_q   <= r_nx;
               q_q   <= {q_q[QBITS-2:0], ge};
               cnt_q <= cnt_q + 1'b1;
            end
            ROUND: begin
               y_q   <= y_rnd;
               ovf_q <= ovf_rnd;
            end
            default: ;
         endcase
      end
   end

   // result is presented during ROUND and held in y_q afterwards
   assign ready     = (state == IDLE);
   assign valid_out = (state == ROUND);
   assign y         = valid_out ? y_rnd : y_q;
   assign ovf       = valid_out ? ovf_rnd : ovf_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: exact integer-division model with RNE, per-cycle output compare,
// directed special cases, mid-operation reset and a randomized streaming regression.
module tb_fdiv_iter;

   localparam int LAT = 28;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] x1 = '0, x2 = '0;
   logic        valid_in = 1'b0;
   logic        ready, ovf, valid_out;
   logic [31:0] y;

   int checks = 0;
   int errors = 0;

   fdiv_iter #(.QBITS(26)) dut (
      .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .valid_in(valid_in),
      .ready(ready), .y(y), .ovf(ovf), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // exact quotient from integer division, then round-to-nearest-even
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, t;
      longint unsigned ma, mb, num, q, rem, keep;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'h0};
      if (eb == 0 && ea != 0)     return {1'b0, s, 8'hFF, 23'h0};
      if (ea == 0)                return {1'b0, s, 31'h0};
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      e  = ea - eb + 127;
      if (ma < mb) begin
         ma = ma * 2;
         e  = e - 1;
      end
      num  = ma << 25;
      q    = num / mb;
      rem  = num % mb;
      keep = q >> 2;
      t    = int'(q & 64'd3) * 2 + ((rem != 0) ? 1 : 0);
      if (t > 4 || (t == 4 && keep[0])) keep = keep + 1;
      if (keep == (64'd1 << 24)) begin
         keep = 64'd1 << 23;
         e    = e + 1;
      end
      if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
      if (e <= 0)   return {1'b0, s, 31'h0};
      return {1'b0, s, 8'(e), keep[22:0]};
   endfunction

   function automatic real sp2real(input logic [31:0] f);
      logic [63:0] d;
      logic [10:0] e;
      e = 11'(f[30:23]) + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] rand_fp();
      int sel;
      logic [7:0] e;
      sel = int'($urandom_range(0, 63));
      if (sel < 6)  return $urandom;
      if (sel < 9)  return {1'($urandom), 31'h0};
      if (sel < 11) return {1'($urandom), 8'hFF, 23'($urandom)};
      if (sel < 24) e = 8'($urandom_range(1, 254));
      else          e = 8'($urandom_range(100, 154));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   // transaction-level model: one op in flight, result due LAT cycles after accept
   int          left;
   logic [31:0] pend_y, pend_a, pend_b, hold_y;
   logic        pend_ovf, hold_ovf;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         left     <= 0;
         hold_y   <= '0;
         hold_ovf <= 1'b0;
      end else if (left > 0) begin
         left <= left - 1;
         if (left == 1) begin
            hold_y   <= pend_y;
            hold_ovf <= pend_ovf;
         end
      end else if (valid_in) begin
         left               <= LAT;
         {pend_ovf, pend_y} <= ref_div(x1, x2);
         pend_a             <= x1;
         pend_b             <= x2;
      end
   end

   real q_ref, y_real, ulp, dif;

   always @(negedge clk) begin
      if (rstn) begin
         check("ready", {32'd0, ready}, {32'd0, (left == 0)});
         check("valid_out", {32'd0, valid_out}, {32'd0, (left == 1)});
         check("y", {1'b0, y}, {1'b0, (left == 1) ? pend_y : hold_y});
         check("ovf", {32'd0, ovf}, {32'd0, (left == 1) ? pend_ovf : hold_ovf});
         if (left == 1 && pend_a[30:23] != 8'h00 && pend_a[30:23] != 8'hFF &&
             pend_b[30:23] != 8'h00 && pend_b[30:23] != 8'hFF &&
             pend_y[30:23] != 8'h00 && pend_y[30:23] != 8'hFF) begin
            q_ref  = sp2real(pend_a) / sp2real(pend_b);
            y_real = sp2real(y);
            ulp    = 2.0 ** (real'(int'(y[30:23])) - 150.0);
            dif    = y_real - q_ref;
            if (dif < 0.0) dif = -dif;
            checks++;
            if (dif > ulp) begin
               errors++;
               $display("FAIL ulp: y %h for %h/%h off by %g, limit %g", y, pend_a, pend_b, dif, ulp);
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eovf);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      x1 = a;
      x2 = b;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      n = 0;
      while (!valid_out && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!valid_out) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no valid_out after %0d cycles, required by %0d", nm, n, LAT);
      end else begin
         check({nm, "_y"}, {1'b0, y}, {1'b0, ey});
         check({nm, "_ovf"}, {32'd0, ovf}, {32'd0, eovf});
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_y", {1'b0, y}, 33'h0);
      check("rst_valid", {32'd0, valid_out}, 33'h0);
      check("rst_ready", {32'd0, ready}, 33'h1);
      check("rst_ovf", {32'd0, ovf}, 33'h0);
      @(negedge clk);
      rstn = 1'b1;

      check("pin_6div2", ref_div(32'h40C00000, 32'h40000000), {1'b0, 32'h40400000});
      check("pin_1div3", ref_div(32'h3F800000, 32'h40400000), {1'b0, 32'h3EAAAAAB});
      check("pin_rne",   ref_div(32'h3FFFFFFF, 32'h3F800001), {1'b0, 32'h3FFFFFFD});
      check("pin_ovf",   ref_div(32'h7F000000, 32'h3E800000), {1'b1, 32'h7F800000});
      check("pin_div0",  ref_div(32'hBF800000, 32'h00000000), {1'b0, 32'hFF800000});
      check("pin_ufl",   ref_div(32'h00800000, 32'h7F000000), {1'b0, 32'h00000000});
      check("pin_zero",  ref_div(32'h80000000, 32'h40000000), {1'b0, 32'h80000000});

      run_op("div_6_2",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      run_op("div_rne",  32'h3FFFFFFF, 32'h3F800001, 32'h3FFFFFFD, 1'b0);
      run_op("div_ovf",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1);
      run_op("div_0",    32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0);
      run_op("div_ufl",  32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
      run_op("div_zero", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
      run_op("div_1_3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);

      // abort an op mid-divide; the held nonzero result must clear at once
      x1 = 32'h40C00000;
      x2 = 32'h40400000;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (9) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("abort_y", {1'b0, y}, 33'h0);
      check("abort_valid", {32'd0, valid_out}, 33'h0);
      check("abort_ready", {32'd0, ready}, 33'h1);
      @(negedge clk);
      #2 rstn = 1'b1;
      run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

      // streaming with valid_in mostly held high and operands changing every cycle
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         valid_in = ($urandom_range(0, 9) != 0);
         x1 = rand_fp();
         x2 = rand_fp();
      end
      @(negedge clk);
      valid_in = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
